// File: rtl/ahmes_mem.sv
// ahmes_mem: word-addressed memory responder for the Ahmes CPU.
// A single array serves a data port (read/write) and an instruction fetch
// port through a three-state handshake FSM with a programmable number of
// wait states. A loader port preloads the array while the FSM is idle.
module ahmes_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1   // legal range 0..7
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active low

  // Data port
  input  logic [ADDR_W-1:0] address_bus,
  input  logic [DATA_W-1:0] data_out,
  input  logic              mem_we,
  input  logic              mem_re,
  output logic [DATA_W-1:0] data_bus,
  output logic              mem_ready,

  // Instruction fetch port
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_re,
  output logic [DATA_W-1:0] instr_bus,
  output logic              instr_ready,

  // Program loader
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,

  // Status
  output logic              busy,
  output logic              mem_error
);

  localparam int DEPTH = 1 << ADDR_W;

  // Counter reload value; a zero wait-state build never enters WAIT.
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  typedef enum logic {
    TAG_DATA,
    TAG_INSTR
  } tag_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  tag_t              tag_q;

  logic              idle;
  logic              take_load;
  logic              take_error;
  logic              take_data;
  logic              take_instr;
  logic              take;
  logic              access_now;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_we;
  logic              acc_instr;

  // Acceptance priority and selection of the access performed this edge.
  // In IDLE the access uses the live inputs (zero wait-state case); in WAIT
  // it uses the values frozen at acceptance.
  always_comb begin
    // NOTE: every signal gets a value on every path so no latch is inferred.
    idle       = (state == S_IDLE);
    take_load  = idle && load_we;
    take_error = idle && !load_we && mem_we && mem_re;
    take_data  = idle && !load_we && (mem_we != mem_re);
    take_instr = idle && !load_we && !mem_we && !mem_re && instr_re;
    take       = take_data || take_instr;
    access_now = (take && (WAIT_STATES == 0)) ||
                 ((state == S_WAIT) && (wait_cnt == 3'd0));

    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    acc_instr = (tag_q == TAG_INSTR);
    if (idle) begin
      acc_addr  = take_data ? address_bus : instr_addr;
      acc_wdata = data_out;
      acc_we    = take_data && mem_we;
      acc_instr = take_instr;
    end
  end

  // Array write port: loader writes in IDLE, data writes on the ACCESS edge.
  // Writes are suppressed while reset is held so an aborted access commits nothing.
  // NOTE: the array itself is never reset; it maps onto RAM and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (take_load) begin
        mem[load_addr] <= load_data;
      end else if (access_now && acc_we) begin
        mem[acc_addr] <= acc_wdata;
      end
    end
  end

  // Handshake FSM with registered read data, ready pulses and error pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      tag_q       <= TAG_DATA;
      data_bus    <= '0;
      instr_bus   <= '0;
      mem_ready   <= 1'b0;
      instr_ready <= 1'b0;
      mem_error   <= 1'b0;
    end else begin
      mem_ready   <= 1'b0;
      instr_ready <= 1'b0;
      // Illegal simultaneous read/write, or a loader strobe during an access.
      mem_error   <= take_error || (!idle && load_we);

      if (take) begin
        addr_q  <= acc_addr;
        wdata_q <= acc_wdata;
        we_q    <= acc_we;
        tag_q   <= take_instr ? TAG_INSTR : TAG_DATA;
      end

      if (access_now) begin
        if (!acc_we) begin
          if (acc_instr) instr_bus <= mem[acc_addr];
          else           data_bus  <= mem[acc_addr];
        end
        if (acc_instr) instr_ready <= 1'b1;
        else           mem_ready   <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (take) begin
            if (WAIT_STATES == 0) begin
              state <= S_ACCESS;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) state <= S_ACCESS;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        S_ACCESS: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Busy is a pure decode of the state register.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ahmes_mem.sv
// Self-checking bench for ahmes_mem. A plain array models the memory
// contents; expected latencies are derived from the wait-state count.
module tb_ahmes_mem;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WS = 2;

  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_FETCH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address_bus = '0;
  logic [DW-1:0] data_out = '0;
  logic          mem_we = 1'b0;
  logic          mem_re = 1'b0;
  logic [DW-1:0] data_bus;
  logic          mem_ready;
  logic [AW-1:0] instr_addr = '0;
  logic          instr_re = 1'b0;
  logic [DW-1:0] instr_bus;
  logic          instr_ready;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          busy;
  logic          mem_error;

  always #5 clk = ~clk;

  ahmes_mem #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .clk         (clk),
    .reset       (reset),
    .address_bus (address_bus),
    .data_out    (data_out),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .data_bus    (data_bus),
    .mem_ready   (mem_ready),
    .instr_addr  (instr_addr),
    .instr_re    (instr_re),
    .instr_bus   (instr_bus),
    .instr_ready (instr_ready),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy),
    .mem_error   (mem_error)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [256];
  logic [DW-1:0] exp_data_bus  = '0;
  logic [DW-1:0] exp_instr_bus = '0;

  // Wait (bounded) for the selected ready pulse; lat = negedges waited, -1 on timeout.
  task automatic wait_ready(input bit instr, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (lat < 0 && n < 16) begin
      @(negedge clk);
      n++;
      if ((instr ? instr_ready : mem_ready) === 1'b1) lat = n;
    end
  endtask

  // One complete access from an idle negedge; returns at the next idle negedge.
  task automatic do_access(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int lat;
    case (kind)
      K_READ:  begin address_bus = addr; mem_re = 1'b1; end
      K_WRITE: begin address_bus = addr; data_out = wdata; mem_we = 1'b1; end
      default: begin instr_addr = addr; instr_re = 1'b1; end
    endcase
    wait_ready(kind == K_FETCH, lat);
    mem_re = 1'b0; mem_we = 1'b0; instr_re = 1'b0;
    checks++;
    if (lat != WS + 1) begin
      errors++;
      $display("FAIL latency kind=%0d addr=%02h: got %0d want %0d", kind, addr, lat, WS + 1);
    end
    if (lat > 0) begin
      case (kind)
        K_READ:  exp_data_bus  = model[addr];
        K_WRITE: model[addr]   = wdata;
        default: exp_instr_bus = model[addr];
      endcase
      checks++;
      if (data_bus !== exp_data_bus || instr_bus !== exp_instr_bus) begin
        errors++;
        $display("FAIL access_data kind=%0d addr=%02h: data_bus=%02h instr_bus=%02h want %02h %02h",
                 kind, addr, data_bus, instr_bus, exp_data_bus, exp_instr_bus);
      end
    end
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || instr_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_access kind=%0d: mem_ready=%b instr_ready=%b busy=%b want 0 0 0",
               kind, mem_ready, instr_ready, busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (data_bus !== 8'h00 || instr_bus !== 8'h00 || mem_ready !== 1'b0 ||
        instr_ready !== 1'b0 || mem_error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%02h instr=%02h rdy=%b irdy=%b err=%b busy=%b want all 0",
               data_bus, instr_bus, mem_ready, instr_ready, mem_error, busy);
    end
    reset = 1'b1;
  endtask

  task automatic test_load;
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      if (busy !== 1'b0 || mem_ready !== 1'b0) bad++;
      load_we   = 1'b1;
      load_addr = 8'(a);
      load_data = 8'($urandom_range(0, 255));
      model[a]  = load_data;
    end
    @(negedge clk); load_addr = 8'h10; load_data = 8'h3C; model[8'h10] = 8'h3C;
    @(negedge clk); load_addr = 8'h00; load_data = 8'h20; model[8'h00] = 8'h20;
    @(negedge clk); load_addr = 8'h40; load_data = 8'h11; model[8'h40] = 8'h11;
    @(negedge clk); load_we = 1'b0;
    checks++;
    if (bad != 0 || busy !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_idle: %0d cycles busy/ready during load, busy=%b want 0", bad, busy);
    end
  endtask

  task automatic test_load_then_read;
    int busy_cnt, rdy_cnt, first;
    busy_cnt = 0; rdy_cnt = 0; first = -1;
    address_bus = 8'h10;
    mem_re = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (mem_ready === 1'b1) begin
        rdy_cnt++;
        if (first < 0) first = i;
        mem_re = 1'b0;
        checks++;
        if (data_bus !== 8'h3C) begin
          errors++;
          $display("FAIL load_read_ready_data: got %02h want 3c", data_bus);
        end
      end
    end
    mem_re = 1'b0;
    exp_data_bus = 8'h3C;
    checks++;
    if (busy_cnt != WS + 1) begin
      errors++;
      $display("FAIL load_read_busy: got %0d cycles want %0d", busy_cnt, WS + 1);
    end
    checks++;
    if (rdy_cnt != 1 || first != WS + 1) begin
      errors++;
      $display("FAIL load_read_ready: pulses=%0d first=%0d want 1 at %0d", rdy_cnt, first, WS + 1);
    end
    checks++;
    if (data_bus !== 8'h3C) begin
      errors++;
      $display("FAIL load_read_hold: got %02h want 3c", data_bus);
    end
  endtask

  task automatic test_arbitration;
    int lat;
    address_bus = 8'h10; mem_re = 1'b1;
    instr_addr  = 8'h00; instr_re = 1'b1;
    wait_ready(1'b0, lat);
    mem_re = 1'b0;
    checks++;
    if (lat != WS + 1 || data_bus !== 8'h3C || instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_data: lat=%0d data=%02h irdy=%b want %0d 3c 0", lat, data_bus, instr_ready, WS + 1);
    end
    exp_data_bus = 8'h3C;
    wait_ready(1'b1, lat);
    instr_re = 1'b0;
    checks++;
    if (lat != WS + 2 || instr_bus !== 8'h20) begin
      errors++;
      $display("FAIL arb_instr: lat=%0d instr=%02h want %0d 20", lat, instr_bus, WS + 2);
    end
    exp_instr_bus = 8'h20;
    @(negedge clk);
  endtask

  task automatic test_illegal;
    int lat;
    address_bus = 8'h22; data_out = ~model[8'h22];
    mem_we = 1'b1; mem_re = 1'b1;
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b0;
    checks++;
    if (mem_error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rw: err=%b busy=%b want 1 0", mem_error, busy);
    end
    @(negedge clk);
    checks++;
    if (mem_error !== 1'b0 || busy !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rw_after: err=%b busy=%b rdy=%b want 0 0 0", mem_error, busy, mem_ready);
    end
    do_access(K_READ, 8'h22, 8'h00);

    address_bus = 8'h30; mem_re = 1'b1;
    @(negedge clk);
    load_we = 1'b1; load_addr = 8'h31; load_data = ~model[8'h31];
    @(negedge clk);
    load_we = 1'b0;
    checks++;
    if (mem_error !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL illegal_load: err=%b busy=%b want 1 1", mem_error, busy);
    end
    wait_ready(1'b0, lat);
    mem_re = 1'b0;
    exp_data_bus = model[8'h30];
    checks++;
    if (lat != WS - 1 || data_bus !== model[8'h30] || mem_error !== 1'b0) begin
      errors++;
      $display("FAIL illegal_load_access: lat=%0d data=%02h err=%b want %0d %02h 0",
               lat, data_bus, mem_error, WS - 1, model[8'h30]);
    end
    @(negedge clk);
    do_access(K_READ, 8'h31, 8'h00);
  endtask

  task automatic test_address_freeze;
    int lat;
    address_bus = 8'hFF; data_out = 8'hA5; mem_we = 1'b1;
    @(negedge clk);
    address_bus = 8'h01; data_out = 8'h5A;
    wait_ready(1'b0, lat);
    mem_we = 1'b0;
    model[8'hFF] = 8'hA5;
    checks++;
    if (lat != WS || data_bus !== exp_data_bus) begin
      errors++;
      $display("FAIL freeze_write: lat=%0d data_bus=%02h want %0d %02h", lat, data_bus, WS, exp_data_bus);
    end
    @(negedge clk);
    do_access(K_READ, 8'hFF, 8'h00);
    checks++;
    if (data_bus !== 8'hA5) begin
      errors++;
      $display("FAIL freeze_read_ff: got %02h want a5", data_bus);
    end
    do_access(K_READ, 8'h01, 8'h00);
  endtask

  task automatic test_reset_during_write;
    int pulses;
    pulses = 0;
    address_bus = 8'h40; data_out = 8'h77; mem_we = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    mem_we = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_ready !== 1'b0 || data_bus !== 8'h00 || instr_bus !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: busy=%b rdy=%b data=%02h instr=%02h want 0 0 00 00",
               busy, mem_ready, data_bus, instr_bus);
    end
    exp_data_bus = 8'h00; exp_instr_bus = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) pulses++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (mem_ready === 1'b1) pulses++;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_write_ready: got %0d pulses want 0", pulses);
    end
    do_access(K_READ, 8'h40, 8'h00);
    checks++;
    if (data_bus !== 8'h11) begin
      errors++;
      $display("FAIL reset_write_kept: got %02h want 11", data_bus);
    end
  endtask

  task automatic test_reset_midcycle;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (data_bus !== 8'h00 || instr_bus !== 8'h00 || mem_ready !== 1'b0 ||
        instr_ready !== 1'b0 || mem_error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcycle: data=%02h instr=%02h busy=%b want 00 00 0", data_bus, instr_bus, busy);
    end
    exp_data_bus = 8'h00; exp_instr_bus = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_access(K_READ, 8'h00, 8'h00);
    checks++;
    if (data_bus !== 8'h20) begin
      errors++;
      $display("FAIL reset_retention: got %02h want 20", data_bus);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      do_access(int'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_load_then_read();
    test_arbitration();
    test_illegal();
    test_address_freeze();
    test_reset_during_write();
    test_random();
    test_reset_midcycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
